cmd_uart_bridge: RTL and testbench

//  Runner-side endpoint of the bluetooth command link. Deserializes two UART bytes
//  (high byte first) into a 16-bit command for the MazeRunner command processor.

---
 rtl/mazerunner_pkg.sv | 11 +
 rtl/uart_tx_core.sv | 79 +++++++
 rtl/cmd_uart_bridge.sv | 169 ++++++++++++++++
 tb/tb_cmd_uart_bridge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mazerunner_pkg.sv
// Shared types and constants for the MazeRunner command link.
package mazerunner_pkg;

  localparam int BAUD_W = 12;
  localparam logic [7:0] RESP_ACK = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} byte_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// Response transmitter: one 10-bit frame {stop,data,start}, LSB first,
// with a done pulse on the cycle after the stop bit ends.
module uart_tx_core
  import mazerunner_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [BAUD_W-1:0] BIT_END = BAUD_W'(BAUD_DIV - 1);

  tx_state_t         state_q, state_d;
  logic [9:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      shift_q <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          shift_d = {1'b1, data_i, 1'b0};
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {1'b1, shift_q[9:1]};
          if (bit_q == 4'd9) begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line is driven from async-reset state so reset forces it high immediately.
  assign tx_o   = (state_q == TX_SHIFT) ? shift_q[0] : 1'b1;
  assign busy_o = (state_q == TX_SHIFT);
  assign done_o = done_q;

endmodule

// File: rtl/cmd_uart_bridge.sv
// Runner-side UART endpoint: two received bytes (high first) form a 16-bit
// command; one response byte is sent back through uart_tx_core.
module cmd_uart_bridge
  import mazerunner_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_END = BAUD_W'(BAUD_DIV / 2 - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT);

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_t         rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              byte_vld_q, byte_vld_d;
  logic              frm_err_q, frm_err_d;

  byte_state_t       byte_state_q, byte_state_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_vld_q   <= 1'b0;
      frm_err_q    <= 1'b0;
      byte_state_q <= WAIT_HI;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      tmo_q        <= '0;
    end else begin
      rx_meta_q    <= RX;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_vld_q   <= byte_vld_d;
      frm_err_q    <= frm_err_d;
      byte_state_q <= byte_state_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      tmo_q        <= tmo_d;
    end
  end

  // Bit-level receiver: start bit is re-checked at mid-bit to reject glitches.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          byte_vld_d = rx_sync_q;
          frm_err_d  = !rx_sync_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Byte pairing. A set of cmd_rdy overrides a clear in the same cycle.
  always_comb begin
    byte_state_d = byte_state_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = cmd_rdy_q;
    tmo_d        = tmo_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (byte_state_q)
      WAIT_HI: begin
        if (byte_vld_q) begin
          cmd_d[15:8]  = rx_shift_q;
          cmd_rdy_d    = 1'b0;
          tmo_d        = TMO_LOAD;
          byte_state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (frm_err_q) begin
          byte_state_d = WAIT_HI;
        end else if (byte_vld_q) begin
          cmd_d[7:0]   = rx_shift_q;
          cmd_rdy_d    = 1'b1;
          byte_state_d = WAIT_HI;
        end else if (rx_state_q == RX_IDLE) begin
          // Timeout only runs while no low-byte frame is in progress.
          if (tmo_q == '0) byte_state_d = WAIT_HI;
          else             tmo_d        = tmo_q - 1'b1;
        end
      end
      default: byte_state_d = WAIT_HI;
    endcase
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;

  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .start_i(send_resp),
    .data_i (resp),
    .tx_o   (TX),
    .busy_o (tx_busy),
    .done_o (resp_sent)
  );

endmodule

// File: tb/tb_cmd_uart_bridge.sv
// Directed bench for cmd_uart_bridge with short baud/timeout settings.
module tb_cmd_uart_bridge;
  import mazerunner_pkg::*;

  localparam int BD  = 16;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;

  int checks = 0;
  int failures = 0;
  int frm_err_cnt = 0;
  int resp_sent_cnt = 0;
  logic [0:0] exp_q[$];

  cmd_uart_bridge #(.BAUD_DIV(BD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err)
  );

  // Clock and pulse monitors
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frm_err) frm_err_cnt++;
    if (resp_sent) resp_sent_cnt++;
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_v;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic wait_cmd_rdy(input string name);
    bit seen = 0;
    for (int i = 0; i < 4 * BD; i++) begin
      if (cmd_rdy) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: cmd_rdy got 0 within %0d cycles, required 1", name, 4 * BD);
    end
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", TX); end
    checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
    checks++; if (resp_sent !== 1'b0) begin failures++; $display("FAIL reset_resp_sent: got %b want 0", resp_sent); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    checks++; if (frm_err !== 1'b0) begin failures++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cmd_basic();
    send_byte(8'h12, 1'b1);
    checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL basic_rdy_after_hi: got %b want 0", cmd_rdy); end
    send_byte(8'h34, 1'b1);
    wait_cmd_rdy("basic_rdy");
    checks++; if (cmd !== 16'h1234) begin failures++; $display("FAIL basic_cmd: got %h want 1234", cmd); end
    @(negedge clk);
    checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL basic_rdy_held: got %b want 1", cmd_rdy); end
    clear_rdy();
    checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL basic_clr: got %b want 0", cmd_rdy); end
    checks++; if (cmd !== 16'h1234) begin failures++; $display("FAIL basic_cmd_stable: got %h want 1234", cmd); end
  endtask

  task automatic test_glitch();
    int fe0 = frm_err_cnt;
    RX = 1'b0;
    repeat (BD / 4) @(negedge clk);
    RX = 1'b1;
    repeat (3 * BD) @(negedge clk);
    checks++; if (frm_err_cnt !== fe0) begin failures++; $display("FAIL glitch_frm_err: got %0d pulses want 0", frm_err_cnt - fe0); end
    checks++; if (dut.byte_state_q !== WAIT_HI) begin failures++; $display("FAIL glitch_state: got %0d want WAIT_HI", dut.byte_state_q); end
    checks++; if (cmd_rdy !== 1'b0 || cmd !== 16'h1234) begin
      failures++; $display("FAIL glitch_cmd: got rdy=%b cmd=%h want rdy=0 cmd=1234", cmd_rdy, cmd);
    end
  endtask

  task automatic test_frame_err();
    int fe0 = frm_err_cnt;
    send_byte(8'h55, 1'b0);
    checks++; if (frm_err_cnt !== fe0 + 1) begin failures++; $display("FAIL ferr_pulse: got %0d pulses want 1", frm_err_cnt - fe0); end
    checks++; if (dut.byte_state_q !== WAIT_HI) begin failures++; $display("FAIL ferr_state: got %0d want WAIT_HI", dut.byte_state_q); end
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    wait_cmd_rdy("ferr_rdy");
    checks++; if (cmd !== 16'hABCD) begin failures++; $display("FAIL ferr_cmd: got %h want abcd", cmd); end
    clear_rdy();
  endtask

  task automatic test_timeout();
    send_byte(8'h77, 1'b1);
    repeat (TMO + 100) @(negedge clk);
    checks++; if (dut.byte_state_q !== WAIT_HI) begin failures++; $display("FAIL tmo_state: got %0d want WAIT_HI", dut.byte_state_q); end
    checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL tmo_rdy: got %b want 0", cmd_rdy); end
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_cmd_rdy("tmo_rdy2");
    checks++; if (cmd !== 16'h0102) begin failures++; $display("FAIL tmo_cmd: got %h want 0102", cmd); end
    clear_rdy();
  endtask

  task automatic tx_frame_check();
    logic [9:0] frame;
    int rs0 = resp_sent_cnt;
    int rs_at = -1;
    frame = {1'b1, RESP_ACK, 1'b0};
    for (int k = 0; k < 10; k++) exp_q.push_back(frame[k]);
    resp = RESP_ACK;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL rsp_busy: got %b want 1", tx_busy); end
    for (int n = 0; n <= 10 * BD + 4; n++) begin
      if (n == 20) begin resp = 8'hFF; send_resp = 1'b1; end
      if (n == 21) send_resp = 1'b0;
      if (n < 10 * BD && (n % BD) == BD / 2) begin
        logic [0:0] e;
        e = exp_q.pop_front();
        checks++;
        if (TX !== e[0]) begin failures++; $display("FAIL rsp_bit%0d: got %b want %b", n / BD, TX, e[0]); end
      end
      if (resp_sent && rs_at < 0) rs_at = n;
      if (n == 10 * BD - 1) begin
        checks++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL rsp_busy_end: got %b want 1", tx_busy); end
      end
      if (n == 10 * BD + 1) begin
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rsp_idle: got %b want 0", tx_busy); end
      end
      @(negedge clk);
    end
    checks++; if (resp_sent_cnt - rs0 !== 1) begin failures++; $display("FAIL rsp_count: got %0d want 1", resp_sent_cnt - rs0); end
    checks++; if (rs_at !== 10 * BD) begin failures++; $display("FAIL rsp_time: got %0d want %0d", rs_at, 10 * BD); end
  endtask

  task automatic test_resp_during_rx();
    fork
      begin
        send_byte(8'h3C, 1'b1);
        send_byte(8'h5A, 1'b1);
      end
      begin
        repeat (8) @(negedge clk);
        tx_frame_check();
      end
    join
    wait_cmd_rdy("dup_rdy");
    checks++; if (cmd !== 16'h3C5A) begin failures++; $display("FAIL dup_cmd: got %h want 3c5a", cmd); end
    clear_rdy();
  endtask

  task automatic test_reset_mid_tx();
    int rs0;
    resp = RESP_ACK;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (2 * BD + BD / 2) @(negedge clk);
    checks++; if (TX !== 1'b0) begin failures++; $display("FAIL rst_pre_tx: got %b want 0", TX); end
    rst = 1'b1;
    #1;
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL rst_tx_high: got %b want 1", TX); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
    rs0 = resp_sent_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BD) @(negedge clk);
    checks++; if (resp_sent_cnt !== rs0) begin failures++; $display("FAIL rst_no_sent: got %0d pulses want 0", resp_sent_cnt - rs0); end
    checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL rst_cmd: got %h want 0000", cmd); end
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_glitch();
    test_frame_err();
    test_timeout();
    test_resp_during_rx();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
